// File: rtl/cache_axi_pkg.sv
// Shared encodings for the cache/memory responder: request type codes,
// responder state and line geometry.
package cache_axi_pkg;

    localparam logic [2:0] BYTE = 3'b000;
    localparam logic [2:0] HALF = 3'b001;
    localparam logic [2:0] WORD = 3'b010;
    localparam logic [2:0] LINE = 3'b100;

    localparam int LINE_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // Only the line code moves a full line; every other code, reserved ones
    // included, is a single word.
    function automatic logic [2:0] beats_of(input logic [2:0] t);
        return (t == LINE) ? 3'(LINE_BEATS) : 3'd1;
    endfunction

endpackage

// File: rtl/cache_mem_responder.sv
// Bridges cache read/write requests onto a synchronous single-port word memory:
// reads stream back one beat per cycle, writes issue one word per cycle.
module cache_mem_responder
    import cache_axi_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_request,
    input  logic [2:0]        read_type,
    input  logic [31:0]       read_addr,
    output logic              read_ready,
    output logic              return_valid,
    output logic              return_last,
    output logic [31:0]       return_data,
    input  logic              write_request,
    input  logic [2:0]        write_type,
    input  logic [31:0]       write_addr,
    input  logic [3:0]        write_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            r_state;
    logic [MEM_AW-1:0] r_waddr;
    logic [2:0]        r_count;
    logic [2:0]        r_beat;
    logic              r_line;
    logic [3:0]        r_wstrb;
    logic [127:0]      r_wdata;
    logic              r_rvalid;
    logic              r_rlast;

    logic [29:0] w_rd_word, w_wr_word, w_rd_base, w_wr_base;
    logic        w_idle, w_in_wr, w_issue, w_last_beat, w_rd_go, w_wr_go;
    logic        w_unused;

    // Lines start at a 16-byte boundary; single beats use the word as given.
    assign w_rd_word = read_addr[31:2];
    assign w_wr_word = write_addr[31:2];
    assign w_rd_base = (read_type == LINE)  ? {w_rd_word[29:2], 2'b00} : w_rd_word;
    assign w_wr_base = (write_type == LINE) ? {w_wr_word[29:2], 2'b00} : w_wr_word;

    assign w_idle      = (r_state == IDLE);
    assign w_in_wr     = (r_state == WR);
    assign w_issue     = (r_state == RD) && (r_beat < r_count);
    assign w_last_beat = (r_beat == r_count - 3'd1);

    assign wr_rdy     = ~reset & w_idle;
    assign read_ready = ~reset & w_idle & ~write_request;
    assign w_wr_go    = write_request & wr_rdy;
    assign w_rd_go    = read_request & read_ready;

    // Outputs are forced low while reset is high, not just from the next edge.
    assign mem_en       = ~reset & (w_issue | w_in_wr);
    assign mem_we       = (~reset & w_in_wr) ? (r_line ? 4'hF : r_wstrb) : 4'h0;
    assign mem_addr     = mem_en ? (r_waddr + MEM_AW'(r_beat)) : '0;
    assign mem_wdata    = (~reset & w_in_wr) ? r_wdata[{r_beat[1:0], 5'd0} +: 32] : 32'h0;
    assign return_valid = ~reset & r_rvalid;
    assign return_last  = ~reset & r_rvalid & r_rlast;
    assign return_data  = return_valid ? mem_rdata : 32'h0;

    assign w_unused = ^{read_addr[1:0], write_addr[1:0], w_rd_base, w_wr_base};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_waddr  <= '0;
            r_count  <= '0;
            r_beat   <= '0;
            r_line   <= 1'b0;
            r_wstrb  <= '0;
            r_wdata  <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_wr_go) begin
                        r_state <= WR;
                        r_waddr <= w_wr_base[MEM_AW-1:0];
                        r_count <= beats_of(write_type);
                        r_line  <= (write_type == LINE);
                        r_wstrb <= write_wstrb;
                        r_wdata <= wr_data;
                        r_beat  <= '0;
                    end else if (w_rd_go) begin
                        r_state <= RD;
                        r_waddr <= w_rd_base[MEM_AW-1:0];
                        r_count <= beats_of(read_type);
                        r_line  <= (read_type == LINE);
                        r_wstrb <= '0;
                        r_beat  <= '0;
                    end
                end
                RD: begin
                    // Memory answers one cycle after issue, so valid/last trail the issue.
                    r_rvalid <= w_issue;
                    r_rlast  <= w_issue & w_last_beat;
                    if (w_issue)
                        r_beat <= r_beat + 3'd1;
                    if (r_rvalid & r_rlast)
                        r_state <= IDLE;
                end
                WR: begin
                    r_beat <= r_beat + 3'd1;
                    if (w_last_beat)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: behavioural RAM, read-beat scoreboard and
// per-scenario cycle checks.
module tb_cache_mem_responder;
    import cache_axi_pkg::*;

    localparam int MEM_AW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              read_request;
    logic [2:0]        read_type;
    logic [31:0]       read_addr;
    logic              read_ready;
    logic              return_valid;
    logic              return_last;
    logic [31:0]       return_data;
    logic              write_request;
    logic [2:0]        write_type;
    logic [31:0]       write_addr;
    logic [3:0]        write_wstrb;
    logic [127:0]      wr_data;
    logic              wr_rdy;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              bk_we = 1'b0;
    logic [MEM_AW-1:0] bk_addr = '0;
    logic [31:0]       bk_data = '0;
    logic [31:0]       ram [0:(1<<MEM_AW)-1];

    int          n_total = 0;
    int          n_pass  = 0;
    logic [32:0] exp_q[$];
    logic [32:0] sb_exp;
    logic [31:0] line_a [4] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};

    always #5 clk = ~clk;

    cache_mem_responder #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset),
        .read_request(read_request), .read_type(read_type), .read_addr(read_addr),
        .read_ready(read_ready),
        .return_valid(return_valid), .return_last(return_last), .return_data(return_data),
        .write_request(write_request), .write_type(write_type), .write_addr(write_addr),
        .write_wstrb(write_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM, 1-cycle read latency, byte enables, plus a backdoor write port.
    always @(posedge clk) begin
        if (bk_we)
            ram[bk_addr] <= bk_data;
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    // Scoreboard: every returned beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (return_valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_beat got last=%b data=%h want no beat", return_last, return_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({return_last, return_data} !== sb_exp)
                    $display("FAIL sb_beat got last=%b data=%h want last=%b data=%h",
                             return_last, return_data, sb_exp[32], sb_exp[31:0]);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        tick();
        bk_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        read_request = 1'b1; read_type = LINE; read_addr = 32'h0000_040C;
        write_request = 1'b1; write_type = LINE; write_addr = 32'h20;
        write_wstrb = 4'hF; wr_data = {4{32'h5A5A5A5A}};
        tick(); tick();
        @(negedge clk);
        n_total++;
        if ({read_ready, wr_rdy, return_valid, return_last, return_data, mem_en, mem_we, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_outputs got rr=%b wr=%b rv=%b rl=%b rd=%h en=%b we=%h a=%h wd=%h want all 0",
                     read_ready, wr_rdy, return_valid, return_last, return_data, mem_en, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        tick();
        read_request = 1'b0; write_request = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({read_ready, wr_rdy} !== 2'b11) $display("FAIL ready_after_reset got %b%b want 11", read_ready, wr_rdy);
        else n_pass++;
        n_total++;
        if ({mem_en, mem_we} !== 5'b0) $display("FAIL idle_mem got en=%b we=%h want 0", mem_en, mem_we);
        else n_pass++;
        tick();
    endtask

    task automatic test_line_read();
        for (int i = 0; i < 4; i++) preload(MEM_AW'(16'h100 + i), line_a[i]);
        read_request = 1'b1; read_type = LINE; read_addr = 32'h0000_040C;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), line_a[i]});
        @(negedge clk);
        n_total++;
        if (read_ready !== 1'b1) $display("FAIL line_read_ready got %b want 1", read_ready); else n_pass++;
        for (int c = 1; c <= 6; c++) begin
            tick();
            read_request = 1'b0;
            @(negedge clk);
            n_total++;
            if (return_valid !== (c >= 2 && c <= 5))
                $display("FAIL line_read_valid c%0d got %b want %b", c, return_valid, (c >= 2 && c <= 5));
            else n_pass++;
            n_total++;
            if (return_last !== (c == 5))
                $display("FAIL line_read_last c%0d got %b want %b", c, return_last, (c == 5));
            else n_pass++;
            if (c <= 4) begin
                n_total++;
                if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'h0, MEM_AW'(16'h100 + c - 1)})
                    $display("FAIL line_read_issue c%0d got en=%b we=%h a=%h want en=1 we=0 a=%h",
                             c, mem_en, mem_we, mem_addr, 16'h100 + c - 1);
                else n_pass++;
            end
        end
        n_total++;
        if (read_ready !== 1'b1) $display("FAIL line_read_ready_after got %b want 1", read_ready); else n_pass++;
        tick();
    endtask

    task automatic test_word_read(input logic [2:0] t, input logic [31:0] a,
                                  input logic [MEM_AW-1:0] exp_word, input logic [31:0] exp_data);
        read_request = 1'b1; read_type = t; read_addr = a;
        exp_q.push_back({1'b1, exp_data});
        @(negedge clk);
        n_total++;
        if (read_ready !== 1'b1) $display("FAIL word_read_ready got %b want 1", read_ready); else n_pass++;
        tick();
        read_request = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_en, mem_addr} !== {1'b1, exp_word})
            $display("FAIL word_read_addr got en=%b a=%h want en=1 a=%h", mem_en, mem_addr, exp_word);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({return_valid, return_last} !== 2'b11)
            $display("FAIL word_read_beat got v=%b l=%b want 11", return_valid, return_last);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({read_ready, return_valid} !== 2'b10)
            $display("FAIL word_read_done got rr=%b v=%b want rr=1 v=0", read_ready, return_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_line_write();
        logic [127:0] d;
        d = 128'h44444444_33333333_22222222_11111111;
        write_request = 1'b1; write_type = LINE; write_addr = 32'h20; write_wstrb = 4'h0; wr_data = d;
        @(negedge clk);
        n_total++;
        if (wr_rdy !== 1'b1) $display("FAIL line_write_rdy got %b want 1", wr_rdy); else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            tick();
            write_request = 1'b0; wr_data = '0;
            @(negedge clk);
            n_total++;
            if (wr_rdy !== 1'b0) $display("FAIL line_write_busy c%0d got %b want 0", c, wr_rdy); else n_pass++;
            n_total++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'hF, MEM_AW'(8 + c - 1), d[32*(c-1) +: 32]})
                $display("FAIL line_write_beat c%0d got en=%b we=%h a=%h d=%h want en=1 we=f a=%h d=%h",
                         c, mem_en, mem_we, mem_addr, mem_wdata, 8 + c - 1, d[32*(c-1) +: 32]);
            else n_pass++;
        end
        tick();
        @(negedge clk);
        n_total++;
        if (wr_rdy !== 1'b1) $display("FAIL line_write_rdy_after got %b want 1", wr_rdy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (ram[8 + i] !== d[32*i +: 32])
                $display("FAIL line_write_ram w%0d got %h want %h", 8 + i, ram[8 + i], d[32*i +: 32]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_single_write(input logic [3:0] strb, input logic [31:0] d, input logic [31:0] exp_word);
        write_request = 1'b1; write_type = BYTE; write_addr = 32'h14; write_wstrb = strb;
        wr_data = {96'h0, d};
        tick();
        write_request = 1'b0;
        @(negedge clk);
        n_total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, strb, MEM_AW'(5)})
            $display("FAIL single_write_issue got en=%b we=%h a=%h want en=1 we=%h a=5", mem_en, mem_we, mem_addr, strb);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if (wr_rdy !== 1'b1) $display("FAIL single_write_done got %b want 1", wr_rdy); else n_pass++;
        n_total++;
        if (ram[5] !== exp_word) $display("FAIL single_write_ram got %h want %h", ram[5], exp_word); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        int acc;
        d = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
        acc = -1;
        write_request = 1'b1; write_type = LINE; write_addr = 32'h30; write_wstrb = 4'h0; wr_data = d;
        read_request = 1'b1; read_type = LINE; read_addr = 32'h34;
        @(negedge clk);
        n_total++;
        if ({read_ready, wr_rdy} !== 2'b01)
            $display("FAIL both_req_ready got rr=%b wr=%b want rr=0 wr=1", read_ready, wr_rdy);
        else n_pass++;
        for (int c = 1; c <= 12 && acc < 0; c++) begin
            tick();
            write_request = 1'b0;
            @(negedge clk);
            if (read_ready === 1'b1) begin
                acc = c;
                for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), d[32*i +: 32]});
            end
        end
        n_total++;
        if (acc != 5) $display("FAIL both_req_accept_cycle got %0d want 5", acc); else n_pass++;
        tick();
        read_request = 1'b0;
        for (int c = 0; c < 12 && exp_q.size() != 0; c++) tick();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL both_req_drain got %0d pending want 0", exp_q.size()); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        read_request = 1'b1; read_type = LINE; read_addr = 32'h0000_040C;
        exp_q.push_back({1'b0, line_a[0]});
        tick();
        read_request = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({read_ready, wr_rdy, return_valid, return_last, return_data, mem_en, mem_we, mem_addr, mem_wdata} !== '0)
            $display("FAIL mid_reset_outputs got rv=%b rd=%h en=%b a=%h want all 0", return_valid, return_data, mem_en, mem_addr);
        else n_pass++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({read_ready, wr_rdy} !== 2'b11) $display("FAIL mid_reset_ready got %b%b want 11", read_ready, wr_rdy); else n_pass++;
        for (int c = 4; c <= 7; c++) begin
            n_total++;
            if ({return_valid, mem_en} !== 2'b00)
                $display("FAIL mid_reset_quiet c%0d got v=%b en=%b want 00", c, return_valid, mem_en);
            else n_pass++;
            tick();
            @(negedge clk);
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL mid_reset_pending got %0d want 0", exp_q.size()); else n_pass++;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        read_request = 1'b0; read_type = '0; read_addr = '0;
        write_request = 1'b0; write_type = '0; write_addr = '0; write_wstrb = '0; wr_data = '0;
        test_reset();
        test_line_read();
        preload(MEM_AW'(2), 32'hDEADBEEF);
        test_word_read(WORD, 32'h0000_0008, MEM_AW'(2), 32'hDEADBEEF);
        test_word_read(3'b111, 32'hFFFC_0408, MEM_AW'(16'h0102), line_a[2]);
        test_line_write();
        preload(MEM_AW'(5), 32'h12345678);
        test_single_write(4'b0010, 32'h0000AB00, 32'h1234AB78);
        test_single_write(4'b0000, 32'hFFFFFFFF, 32'h1234AB78);
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
